mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single AXI-side memory port between instruction fetch (IF) and the load/store unit (MEM).
//   Accepts one request from each side, grants one, and registers it onto the shared port.
//   Holds the grant until the port completes, then routes ready, read data and resp to the winner only.
//   MEM has priority, with a starvation guard for IF. Sits between the fetch/LSU stages and the AXI bridge.
// PARAMETERS
//   STARVE_LIMIT  4   consecutive IF losses while IF is pending; after that IF wins the next arbitration (1..15)
// PORTS
//   clk            in   1   clock
//   rst            in   1   synchronous, active-high reset
//   if_valid       in   1   IF request pending; held until if_ready
//   if_addr        in   64  IF address
//   if_size        in   2   IF transfer size
//   if_ready       out  1   1-cycle completion pulse to IF
//   if_data_read   out  64  read data to IF; valid when if_ready=1
//   if_resp        out  2   response to IF; valid when if_ready=1
//   mem_valid      in   1   MEM request pending; held until mem_ready
//   mem_wr         in   1   1=write, 0=read
//   mem_addr       in   64  MEM address
//   mem_size       in   2   MEM transfer size
//   mem_wdata      in   64  MEM write data
//   mem_wstrb      in   8   MEM byte strobes
//   mem_ready      out  1   1-cycle completion pulse to MEM
//   mem_data_read  out  64  read data to MEM; valid when mem_ready=1
//   mem_resp       out  2   response to MEM; valid when mem_ready=1
//   axi_valid      out  1   shared-port request valid (registered)
//   axi_wr         out  1   shared-port write flag (registered)
//   axi_addr       out  64  shared-port address (registered)
//   axi_size       out  2   shared-port size (registered)
//   axi_wdata      out  64  shared-port write data (registered)
//   axi_wstrb      out  8   shared-port strobes (registered)
//   axi_ready      in   1   shared-port 1-cycle completion pulse
//   axi_data_read  in   64  shared-port read data
//   axi_resp       in   2   shared-port response
//   owner          out  1   current grant: 0=IF, 1=MEM; meaningful only while axi_valid=1
// BEHAVIOUR
//   - Reset: state=IDLE; starve_cnt=0; all registered axi_* outputs=0; owner=0.
//     if_ready and mem_ready are 0 because state=IDLE.
//   - FSM states: IDLE, BUSY_IF, BUSY_MEM.
//   - IDLE, neither valid: stay in IDLE; axi_valid=0.
//   - IDLE, only one valid: grant that side.
//   - IDLE, both valid: grant MEM, unless starve_cnt>=STARVE_LIMIT, in which case grant IF.
//   - On a grant edge:
//       latch the winner's addr/size into axi_addr/axi_size;
//       for MEM also latch wr/wdata/wstrb; IF forces axi_wr=0, axi_wdata=0, axi_wstrb=0;
//       set axi_valid=1 and owner;
//       move to BUSY_IF or BUSY_MEM. axi_valid rises the cycle after the request is seen.
//   - starve_cnt: +1 (saturating at 15) on each MEM grant made while if_valid=1; cleared on every IF grant.
//   - BUSY_x: axi_* outputs are held stable; new requests are ignored.
//   - BUSY_x with axi_ready=1:
//       combinationally x_ready=1 and x_data_read/x_resp = axi_data_read/axi_resp in the same cycle;
//       next cycle axi_valid=0, state=IDLE.
//   - Outside that completion cycle: if_ready=mem_ready=0 and both data/resp outputs=0.
//     The non-owner never sees a ready pulse.
//   - Minimum occupancy is 2 cycles per transfer (IDLE grant + BUSY completion), so back-to-back
//     transfers always have one IDLE cycle between them.
//   - Requester drops valid while BUSY: the transfer still completes on the port and the ready pulse
//     is still delivered; the requester must tolerate it.
//   - axi_ready=1 in IDLE: ignored, no ready pulse to either side.
//   - axi_resp != 0 is forwarded unchanged; the arbiter takes no error action.
//   - rst during BUSY: next cycle IDLE and axi_valid=0; the in-flight transfer is abandoned and the
//     bridge must be reset by the same rst.
// TESTING
//   1. if_valid=1, addr=0x80000000, size=2; axi_ready pulsed 3 cycles after axi_valid
//      -> axi_addr=0x80000000, axi_wr=0; if_ready pulses once with the data; mem_ready stays 0.
//   2. mem_valid=1, wr=1, addr=0x80001000, wdata=0x1122334455667788, wstrb=0xFF
//      -> axi_* carry exactly these values; mem_ready pulses on axi_ready.
//   3. if_valid and mem_valid rise in the same cycle
//      -> MEM is granted first; after its completion plus one IDLE cycle, IF is granted at its address.
//   4. STARVE_LIMIT=2; mem_valid held high continuously with if_valid=1
//      -> MEM wins two grants, IF wins the third, and starve_cnt returns to 0.
//   5. rst asserted while in BUSY_MEM
//      -> next cycle axi_valid=0, owner=0, state=IDLE; a later axi_ready pulse produces no x_ready.
//   6. axi_resp=2'b10 on an IF read -> if_resp=2'b10 on the if_ready cycle; mem_resp stays 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the IF/MEM to shared memory port arbiter.
// master is the arbiter side and slave is the environment side.
interface mem_port_arbiter_if;
  logic        if_valid;
  logic [63:0] if_addr;
  logic [1:0]  if_size;
  logic        if_ready;
  logic [63:0] if_data_read;
  logic [1:0]  if_resp;

  logic        mem_valid;
  logic        mem_wr;
  logic [63:0] mem_addr;
  logic [1:0]  mem_size;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ready;
  logic [63:0] mem_data_read;
  logic [1:0]  mem_resp;

  logic        axi_valid;
  logic        axi_wr;
  logic [63:0] axi_addr;
  logic [1:0]  axi_size;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_ready;
  logic [63:0] axi_data_read;
  logic [1:0]  axi_resp;

  logic        owner;

  modport master (
    input  if_valid, if_addr, if_size,
    output if_ready, if_data_read, if_resp,
    input  mem_valid, mem_wr, mem_addr,
    input  mem_size, mem_wdata, mem_wstrb,
    output mem_ready, mem_data_read, mem_resp,
    output axi_valid, axi_wr, axi_addr,
    output axi_size, axi_wdata, axi_wstrb,
    input  axi_ready, axi_data_read, axi_resp,
    output owner
  );

  modport slave (
    output if_valid, if_addr, if_size,
    input  if_ready, if_data_read, if_resp,
    output mem_valid, mem_wr, mem_addr,
    output mem_size, mem_wdata, mem_wstrb,
    input  mem_ready, mem_data_read, mem_resp,
    input  axi_valid, axi_wr, axi_addr,
    input  axi_size, axi_wdata, axi_wstrb,
    output axi_ready, axi_data_read, axi_resp,
    input  owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store.
// MEM has priority; a starvation counter eventually lets IF through.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_MEM
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  starve_cnt;
  logic        grant_if;
  logic        grant_mem;
  logic        done;

  logic        valid_q;
  logic        wr_q;
  logic [63:0] addr_q;
  logic [1:0]  size_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  logic        owner_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.if_valid &&
            (!bus.mem_valid ||
             starve_cnt >= LIMIT)) begin
          grant_if  = 1'b1;
          state_nxt = BUSY_IF;
        end else if (bus.mem_valid) begin
          grant_mem = 1'b1;
          state_nxt = BUSY_MEM;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        done = bus.axi_ready;
        if (bus.axi_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.if_ready      = 1'b0;
    bus.if_data_read  = '0;
    bus.if_resp       = '0;
    bus.mem_ready     = 1'b0;
    bus.mem_data_read = '0;
    bus.mem_resp      = '0;
    if (done && state == BUSY_IF) begin
      bus.if_ready     = 1'b1;
      bus.if_data_read = bus.axi_data_read;
      bus.if_resp      = bus.axi_resp;
    end
    if (done && state == BUSY_MEM) begin
      bus.mem_ready     = 1'b1;
      bus.mem_data_read = bus.axi_data_read;
      bus.mem_resp      = bus.axi_resp;
    end
  end

  // Port registers only change on a grant or a completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      owner_q <= 1'b0;
    end else if (grant_mem) begin
      valid_q <= 1'b1;
      wr_q    <= bus.mem_wr;
      addr_q  <= bus.mem_addr;
      size_q  <= bus.mem_size;
      wdata_q <= bus.mem_wdata;
      wstrb_q <= bus.mem_wstrb;
      owner_q <= 1'b1;
    end else if (grant_if) begin
      valid_q <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= bus.if_addr;
      size_q  <= bus.if_size;
      wdata_q <= '0;
      wstrb_q <= '0;
      owner_q <= 1'b0;
    end else if (done) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if (grant_if)
      starve_cnt <= '0;
    else if (grant_mem && bus.if_valid &&
             starve_cnt != 4'hF)
      starve_cnt <= starve_cnt + 4'd1;
  end

  assign bus.axi_valid = valid_q;
  assign bus.axi_wr    = wr_q;
  assign bus.axi_addr  = addr_q;
  assign bus.axi_size  = size_q;
  assign bus.axi_wdata = wdata_q;
  assign bus.axi_wstrb = wstrb_q;
  assign bus.owner     = owner_q;

endmodule
